// File: rtl/pendulum_pkg.sv
// Shared state encoding and default limits for the pendulum sweep block.
package pendulum_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SWING_FWD = 3'd1,
    DWELL_HI  = 3'd2,
    SWING_REV = 3'd3,
    DWELL_LO  = 3'd4
  } sweep_state_t;

  localparam logic [15:0] DEF_POS_MIN     = 16'd0;
  localparam logic [15:0] DEF_POS_MAX     = 16'd1000;
  localparam logic [15:0] DEF_STEP        = 16'd10;
  localparam logic [31:0] DEF_DWELL_TICKS = 32'd0;
  localparam logic [31:0] DEF_PWM_PERIOD  = 32'd20000;

endpackage

// File: rtl/pendulum_sweep_if.sv
// Tick/enable inputs and swing status outputs of pendulum_sweep.
interface pendulum_sweep_if #(
  parameter int unsigned POS_WIDTH = 16
);
  logic                 ce_in;
  logic                 enable;
  logic [POS_WIDTH-1:0] position;
  logic                 direction;
  logic                 at_extreme;

  modport master (
    output ce_in, enable,
    input  position, direction, at_extreme
  );

  modport slave (
    input  ce_in, enable,
    output position, direction, at_extreme
  );
endinterface

// File: rtl/pendulum_pwm.sv
// Free-running PWM whose duty follows the swing position (used with PENDULUM_PWM_EN).
module pendulum_pwm
  import pendulum_pkg::*;
#(
  parameter int unsigned   POS_WIDTH  = 16,
  parameter logic [31:0]   PWM_PERIOD = DEF_PWM_PERIOD
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic [POS_WIDTH-1:0] position,
  output logic                 pwm_out
);

  localparam int unsigned CW = (POS_WIDTH > 32) ? POS_WIDTH : 32;

  logic [31:0]   cnt;
  logic [CW-1:0] cnt_w;
  logic [CW-1:0] pos_w;

  assign cnt_w = CW'(cnt);
  assign pos_w = CW'(position);

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      cnt     <= '0;
      pwm_out <= 1'b0;
    end else begin
      cnt     <= (cnt == PWM_PERIOD - 32'd1) ? '0 : cnt + 32'd1;
      pwm_out <= (cnt_w < pos_w);
    end
  end

endmodule

// File: rtl/pendulum_sweep.sv
// Pendulum position sweeper: ramps between POS_MIN and POS_MAX on ticks, optional dwell.
// Optional PWM output is built only when PENDULUM_PWM_EN is defined.
module pendulum_sweep
  import pendulum_pkg::*;
#(
  parameter int unsigned          POS_WIDTH   = 16,
  parameter logic [POS_WIDTH-1:0] POS_MIN     = DEF_POS_MIN,
  parameter logic [POS_WIDTH-1:0] POS_MAX     = DEF_POS_MAX,
  parameter logic [POS_WIDTH-1:0] STEP        = DEF_STEP,
  parameter logic [31:0]          DWELL_TICKS = DEF_DWELL_TICKS
`ifdef PENDULUM_PWM_EN
  ,
  parameter logic [31:0]          PWM_PERIOD  = DEF_PWM_PERIOD
`endif
) (
  input  logic             clk_in,
  input  logic             reset_n,
  pendulum_sweep_if.slave  bus
`ifdef PENDULUM_PWM_EN
  ,
  output logic             pwm_out
`endif
);

  sweep_state_t         state, state_nxt;
  logic [POS_WIDTH-1:0] pos_q, pos_nxt;
  logic                 dir_q, dir_nxt;
  logic                 ext_q, ext_nxt;
  logic [31:0]          dwell_q, dwell_nxt;
  logic                 tick;
  logic                 reached;
  logic [POS_WIDTH:0]   fwd_sum;
  logic [POS_WIDTH:0]   rev_floor;
  logic                 dwell_last;

  assign tick       = bus.ce_in & bus.enable;
  // One extra bit on both sides so neither the sum nor the floor can wrap.
  assign fwd_sum    = {1'b0, pos_q} + {1'b0, STEP};
  assign rev_floor  = {1'b0, POS_MIN} + {1'b0, STEP};
  assign dwell_last = (dwell_q == DWELL_TICKS - 32'd1);

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state   <= IDLE;
      pos_q   <= POS_MIN;
      dir_q   <= 1'b0;
      ext_q   <= 1'b0;
      dwell_q <= '0;
    end else begin
      state   <= state_nxt;
      pos_q   <= pos_nxt;
      dir_q   <= dir_nxt;
      ext_q   <= ext_nxt;
      dwell_q <= dwell_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos_q;
    dir_nxt   = dir_q;
    dwell_nxt = dwell_q;
    reached   = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          state_nxt = SWING_FWD;
          dir_nxt   = 1'b1;
        end
        SWING_FWD: begin
          if (fwd_sum >= {1'b0, POS_MAX}) begin
            pos_nxt = POS_MAX;
            reached = 1'b1;
            if (DWELL_TICKS != 32'd0) begin
              state_nxt = DWELL_HI;
            end else begin
              state_nxt = SWING_REV;
              dir_nxt   = 1'b0;
            end
          end else begin
            pos_nxt = fwd_sum[POS_WIDTH-1:0];
          end
        end
        SWING_REV: begin
          if ({1'b0, pos_q} <= rev_floor) begin
            pos_nxt = POS_MIN;
            reached = 1'b1;
            if (DWELL_TICKS != 32'd0) begin
              state_nxt = DWELL_LO;
            end else begin
              state_nxt = SWING_FWD;
              dir_nxt   = 1'b1;
            end
          end else begin
            pos_nxt = pos_q - STEP;
          end
        end
        DWELL_HI: begin
          if (dwell_last) begin
            dwell_nxt = '0;
            state_nxt = SWING_REV;
            dir_nxt   = 1'b0;
          end else begin
            dwell_nxt = dwell_q + 32'd1;
          end
        end
        DWELL_LO: begin
          if (dwell_last) begin
            dwell_nxt = '0;
            state_nxt = SWING_FWD;
            dir_nxt   = 1'b1;
          end else begin
            dwell_nxt = dwell_q + 32'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    // Suppressed after a pulse so back-to-back limits (STEP == full range) stay single-cycle.
    ext_nxt = reached & ~ext_q;
  end

  assign bus.position   = pos_q;
  assign bus.direction  = dir_q;
  assign bus.at_extreme = ext_q;

`ifdef PENDULUM_PWM_EN
  pendulum_pwm #(
    .POS_WIDTH  (POS_WIDTH),
    .PWM_PERIOD (PWM_PERIOD)
  ) u_pwm (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .position (pos_q),
    .pwm_out  (pwm_out)
  );
`endif

endmodule
